// File: rtl/control_32_pkg.sv
// Shared opcode/funct constants, control-field encodings and the control payload struct
// for the MIPS main control decoder.
package control_32_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned FN_W  = 6;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [FN_W-1:0] FN_JR = 6'b001000;

  localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] WB_ALU = 2'b00;
  localparam logic [SEL_W-1:0] WB_MEM = 2'b01;
  localparam logic [SEL_W-1:0] WB_PC4 = 2'b10;

  localparam logic [SEL_W-1:0] BR_NONE = 2'b00;
  localparam logic [SEL_W-1:0] BR_EQ   = 2'b01;
  localparam logic [SEL_W-1:0] BR_NE   = 2'b10;

  localparam logic [SEL_W-1:0] DST_RT = 2'b00;
  localparam logic [SEL_W-1:0] DST_RD = 2'b01;
  localparam logic [SEL_W-1:0] DST_RA = 2'b10;

  localparam logic [SEL_W-1:0] JMP_NONE = 2'b00;
  localparam logic [SEL_W-1:0] JMP_TGT  = 2'b01;
  localparam logic [SEL_W-1:0] JMP_REG  = 2'b10;

  typedef struct packed {
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] mem_toreg;
    logic             mem_write;
    logic             mem_read;
    logic [SEL_W-1:0] branch;
    logic             alu_src;
    logic [SEL_W-1:0] reg_dst;
    logic             reg_write;
    logic [SEL_W-1:0] jump;
  } ctrl_t;

endpackage

// File: rtl/mips_control_32_if.sv
// Instruction-field inputs and registered control outputs of the MIPS main control decoder.
interface mips_control_32_if;
  import control_32_pkg::*;

  logic [OP_W-1:0]  opcode;
  logic [FN_W-1:0]  funct;
  logic [SEL_W-1:0] alu_op;
  logic [SEL_W-1:0] mem_toreg;
  logic             mem_write;
  logic             mem_read;
  logic [SEL_W-1:0] branch;
  logic             alu_src;
  logic [SEL_W-1:0] reg_dst;
  logic             reg_write;
  logic [SEL_W-1:0] jump;
  logic             err_illegal_opcode;

  modport master (
    output opcode, funct,
    input  alu_op, mem_toreg, mem_write, mem_read, branch, alu_src,
           reg_dst, reg_write, jump, err_illegal_opcode
  );

  modport slave (
    input  opcode, funct,
    output alu_op, mem_toreg, mem_write, mem_read, branch, alu_src,
           reg_dst, reg_write, jump, err_illegal_opcode
  );
endinterface

// File: rtl/control_32_decode.sv
// Combinational opcode/funct decode table producing the next control word and illegal flag.
module control_32_decode
  import control_32_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  output ctrl_t           ctrl_c,
  output logic            illegal_c
);

  always_comb begin
    ctrl_c    = '0;
    illegal_c = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          ctrl_c.jump = JMP_REG;
        end else begin
          ctrl_c.alu_op    = ALU_FUNCT;
          ctrl_c.reg_dst   = DST_RD;
          ctrl_c.reg_write = 1'b1;
        end
      end
      OP_LW: begin
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.mem_toreg = WB_MEM;
        ctrl_c.reg_dst   = DST_RT;
        ctrl_c.reg_write = 1'b1;
      end
      OP_SW: begin
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_c.alu_op = ALU_SUB;
        ctrl_c.branch = BR_EQ;
      end
      OP_BNE: begin
        ctrl_c.alu_op = ALU_SUB;
        ctrl_c.branch = BR_NE;
      end
      OP_ADDI: begin
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.reg_dst   = DST_RT;
        ctrl_c.reg_write = 1'b1;
      end
      OP_J: begin
        ctrl_c.jump = JMP_TGT;
      end
      OP_JAL: begin
        ctrl_c.jump      = JMP_TGT;
        ctrl_c.reg_dst   = DST_RA;
        ctrl_c.mem_toreg = WB_PC4;
        ctrl_c.reg_write = 1'b1;
      end
      // Unsupported opcodes leave every control at zero so nothing is written.
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_control_32.sv
// MIPS main control: registers the decode table output with 1-cycle latency.
// CONTROL_32_STICKY_ERR_EN: err_illegal_opcode holds at 1 until reset once raised.
module mips_control_32
  import control_32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mips_control_32_if.slave  bus
);

  ctrl_t ctrl_c;
  ctrl_t ctrl_q;
  logic  illegal_c;
  logic  err_d;
  logic  err_q;

  control_32_decode u_decode (
    .opcode    (bus.opcode),
    .funct     (bus.funct),
    .ctrl_c    (ctrl_c),
    .illegal_c (illegal_c)
  );

`ifdef CONTROL_32_STICKY_ERR_EN
  assign err_d = illegal_c | err_q;
`else
  assign err_d = illegal_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_c;
      err_q  <= err_d;
    end
  end

  assign bus.alu_op             = ctrl_q.alu_op;
  assign bus.mem_toreg          = ctrl_q.mem_toreg;
  assign bus.mem_write          = ctrl_q.mem_write;
  assign bus.mem_read           = ctrl_q.mem_read;
  assign bus.branch             = ctrl_q.branch;
  assign bus.alu_src            = ctrl_q.alu_src;
  assign bus.reg_dst            = ctrl_q.reg_dst;
  assign bus.reg_write          = ctrl_q.reg_write;
  assign bus.jump               = ctrl_q.jump;
  assign bus.err_illegal_opcode = err_q;

endmodule

// File: tb/tb_mips_control_32.sv
// Directed-vector bench for mips_control_32; expected control words are hand-written constants.
module tb_mips_control_32;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mips_control_32_if bus ();

  mips_control_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CONTROL_32_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  // {alu_op, mem_toreg, mem_write, mem_read, branch, alu_src, reg_dst, reg_write, jump, err}
  function automatic logic [15:0] mk(input logic [1:0] alu, input logic [1:0] wb,
                                     input logic mw, input logic mr, input logic [1:0] br,
                                     input logic as, input logic [1:0] rd, input logic rw,
                                     input logic [1:0] j, input logic e);
    return {alu, wb, mw, mr, br, as, rd, rw, j, e};
  endfunction

  function automatic logic [15:0] observed();
    return {bus.alu_op, bus.mem_toreg, bus.mem_write, bus.mem_read, bus.branch,
            bus.alu_src, bus.reg_dst, bus.reg_write, bus.jump, bus.err_illegal_opcode};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.funct  = fn;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] e_rtype, e_lw, e_sw, e_beq, e_bne, e_addi, e_j, e_jal, e_jr, e_ill;
  logic [5:0]  leg_op [9];
  logic [5:0]  leg_fn [9];
  logic [15:0] leg_ex [9];
  logic [5:0]  ill_op [6];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    e_rtype = mk(2'b10, 2'b00, 0, 0, 2'b00, 0, 2'b01, 1, 2'b00, 0);
    e_lw    = mk(2'b00, 2'b01, 0, 1, 2'b00, 1, 2'b00, 1, 2'b00, 0);
    e_sw    = mk(2'b00, 2'b00, 1, 0, 2'b00, 1, 2'b00, 0, 2'b00, 0);
    e_beq   = mk(2'b01, 2'b00, 0, 0, 2'b01, 0, 2'b00, 0, 2'b00, 0);
    e_bne   = mk(2'b01, 2'b00, 0, 0, 2'b10, 0, 2'b00, 0, 2'b00, 0);
    e_addi  = mk(2'b00, 2'b00, 0, 0, 2'b00, 1, 2'b00, 1, 2'b00, 0);
    e_j     = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 2'b01, 0);
    e_jal   = mk(2'b00, 2'b10, 0, 0, 2'b00, 0, 2'b10, 1, 2'b01, 0);
    e_jr    = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 2'b10, 0);
    e_ill   = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 1);

    leg_op = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
               6'b001000, 6'b000010, 6'b000011, 6'b000000};
    leg_fn = '{6'b100000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
               6'b000000, 6'b000000, 6'b000000, 6'b001000};
    leg_ex = '{e_rtype, e_lw, e_sw, e_beq, e_bne, e_addi, e_j, e_jal, e_jr};
    ill_op = '{6'b001110, 6'b111111, 6'b111011, 6'b011110, 6'b111010, 6'b100111};

    // Reset held with LW on the inputs.
    rst_n      = 1'b0;
    bus.opcode = 6'b100011;
    bus.funct  = 6'b000000;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_hold", observed(), 16'h0000);
    rst_n = 1'b1;
    #1;
    check_eq("reset_release_no_edge", observed(), 16'h0000);
    @(posedge clk);
    #1;
    check_eq("first_edge_lw", observed(), e_lw);

    for (int i = 0; i < 9; i++) begin
      step(leg_op[i], leg_fn[i]);
      check_eq($sformatf("legal_%0d_op%06b", i, leg_op[i]), observed(), leg_ex[i]);
    end

    step(6'b000100, 6'b000000);
    check_eq("b2b_beq", observed(), e_beq);
    step(6'b000101, 6'b000000);
    check_eq("b2b_bne", observed(), e_bne);
    step(6'b000100, 6'b000000);
    check_eq("b2b_beq2", observed(), e_beq);

    for (int i = 0; i < 6; i++) begin
      step(ill_op[i], 6'b000000);
      check_eq($sformatf("illegal_op%06b", ill_op[i]), observed(), e_ill);
    end

    step(6'b111111, 6'b000000);
    check_eq("ill_before_sw", observed(), e_ill);
    step(6'b101011, 6'b000000);
    check_eq("sw_after_ill", observed(), e_sw | {15'd0, STICKY});
    step(6'b000011, 6'b000000);
    check_eq("jal_registered", observed(), e_jal | {15'd0, STICKY});

    // Asynchronous reset mid-cycle must clear outputs before the next edge.
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_mid_cycle", observed(), 16'h0000);
    @(posedge clk);
    #1;
    check_eq("reset_held_edge", observed(), 16'h0000);
    rst_n = 1'b1;
    step(6'b001000, 6'b000000);
    check_eq("addi_after_reset", observed(), e_addi);
    step(6'b000000, 6'b101010);
    check_eq("rtype_slt", observed(), e_rtype);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
